// File: rtl/qubit_readout_pkg.sv
// Shared widths and types for the qubit readout chain (integrator and classify).
package qubit_readout_pkg;

  localparam int SAMPLE_W_DEF = 16;
  localparam int ACC_W_DEF    = 32;
  localparam int LEN_W_DEF    = 16;

  typedef enum logic [1:0] {
    IDLE,
    DELAY,
    INTEGRATE,
    EMIT
  } integ_state_t;

  typedef logic [1:0] class_state_t;

endpackage

// File: rtl/iq_integrator_if.sv
// Trigger, window, sample and result signals between the ADC front end and the integrator.
interface iq_integrator_if
  import qubit_readout_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
);

  logic                       trigger;
  logic        [LEN_W-1:0]    win_delay;
  logic        [LEN_W-1:0]    win_len;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] i_sample;
  logic signed [SAMPLE_W-1:0] q_sample;
  logic signed [ACC_W-1:0]    i_val;
  logic signed [ACC_W-1:0]    q_val;
  logic                       data_out;
  logic                       busy;
  logic                       overrun;

  modport master (
    output trigger, win_delay, win_len, sample_valid, i_sample, q_sample,
    input  i_val, q_val, data_out, busy, overrun
  );

  modport slave (
    input  trigger, win_delay, win_len, sample_valid, i_sample, q_sample,
    output i_val, q_val, data_out, busy, overrun
  );

endinterface

// File: rtl/iq_accum_lane.sv
// One signed accumulator lane: clear to zero, or add a sign-extended sample when enabled.
module iq_accum_lane #(
  parameter int SAMPLE_W = 16,
  parameter int ACC_W    = 32
) (
  input  logic                       clk100,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       en,
  input  logic signed [SAMPLE_W-1:0] sample,
  output logic signed [ACC_W-1:0]    sum
);

  logic signed [ACC_W-1:0] sample_ext;

  assign sample_ext = {{(ACC_W-SAMPLE_W){sample[SAMPLE_W-1]}}, sample};

  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      sum <= '0;
    end else if (clear) begin
      sum <= '0;
    end else if (en) begin
      sum <= sum + sample_ext;
    end
  end

endmodule

// File: rtl/iq_integrator.sv
// Boxcar integrator: after a trigger, skips win_delay valid samples, sums win_len valid
// I/Q samples, then presents the sums for one strobe cycle and holds them afterwards.
module iq_integrator
  import qubit_readout_pkg::*;
#(
  parameter int SAMPLE_W = SAMPLE_W_DEF,
  parameter int ACC_W    = ACC_W_DEF,
  parameter int LEN_W    = LEN_W_DEF
) (
  input logic             clk100,
  input logic             rst_n,
  iq_integrator_if.slave  bus
);

  if (ACC_W < SAMPLE_W + LEN_W) begin : g_width_check
    $error("iq_integrator: ACC_W must be >= SAMPLE_W + LEN_W");
  end

  integ_state_t            state;
  integ_state_t            state_next;
  logic [LEN_W-1:0]        delay_cnt;
  logic [LEN_W-1:0]        delay_next;
  logic [LEN_W-1:0]        len_cnt;
  logic [LEN_W-1:0]        len_next;
  logic                    acc_clear;
  logic                    acc_en;
  logic                    start_ok;
  logic signed [ACC_W-1:0] acc_i;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] i_hold;
  logic signed [ACC_W-1:0] q_hold;

  assign start_ok = bus.trigger && (state == IDLE) && (bus.win_len != '0);

  always_comb begin
    state_next = state;
    delay_next = delay_cnt;
    len_next   = len_cnt;
    acc_clear  = 1'b0;
    acc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (start_ok) begin
          acc_clear  = 1'b1;
          delay_next = bus.win_delay;
          len_next   = bus.win_len;
          state_next = (bus.win_delay != '0) ? DELAY : INTEGRATE;
        end
      end
      DELAY: begin
        if (bus.sample_valid) begin
          delay_next = delay_cnt - LEN_W'(1);
          if (delay_cnt == LEN_W'(1)) state_next = INTEGRATE;
        end
      end
      INTEGRATE: begin
        if (bus.sample_valid) begin
          acc_en   = 1'b1;
          len_next = len_cnt - LEN_W'(1);
          if (len_cnt == LEN_W'(1)) state_next = EMIT;
        end
      end
      EMIT:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The held outputs are captured at the end of EMIT; during EMIT the live sums are shown.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      delay_cnt <= '0;
      len_cnt   <= '0;
      i_hold    <= '0;
      q_hold    <= '0;
    end else begin
      state     <= state_next;
      delay_cnt <= delay_next;
      len_cnt   <= len_next;
      if (state == EMIT) begin
        i_hold <= acc_i;
        q_hold <= acc_q;
      end
    end
  end

  iq_accum_lane #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_lane_i (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .en     (acc_en),
    .sample (bus.i_sample),
    .sum    (acc_i)
  );

  iq_accum_lane #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_lane_q (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .en     (acc_en),
    .sample (bus.q_sample),
    .sum    (acc_q)
  );

  assign bus.data_out = (state == EMIT);
  assign bus.busy     = (state != IDLE);
  assign bus.i_val    = (state == EMIT) ? acc_i : i_hold;
  assign bus.q_val    = (state == EMIT) ? acc_q : q_hold;
  assign bus.overrun  = bus.trigger && ((state != IDLE) || (bus.win_len == '0));

endmodule

// File: tb/tb_iq_integrator.sv
// Scoreboard bench for iq_integrator: the driver models each window with plain sums and
// queues the expected point; a negedge monitor pops and compares on every strobe.
module tb_iq_integrator;

  typedef struct {
    longint i;
    longint q;
    int     cyc;
  } exp_t;

  logic clk100;
  logic rst_n;
  int   cyc;
  int   errors;
  int   checks;

  exp_t   exp_q[$];
  exp_t   e;
  longint held_i;
  longint held_q;

  int fv[$];
  int fi[$];
  int fq[$];
  bit use_const;
  int const_i;
  int const_q;

  iq_integrator_if bus ();

  iq_integrator dut (
    .clk100 (clk100),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  initial clk100 = 1'b0;
  always #5 clk100 = ~clk100;

  initial cyc = 0;
  always @(posedge clk100) cyc++;

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: strobes pop the scoreboard; other cycles confirm the outputs are held.
  always @(negedge clk100) begin
    if (rst_n) begin
      if (bus.data_out) begin
        if (exp_q.size() == 0) begin
          check("unexpected_strobe", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("i_val", bus.i_val, e.i);
          check("q_val", bus.q_val, e.q);
          check("strobe_cycle", cyc, e.cyc);
          held_i = e.i;
          held_q = e.q;
        end
      end else begin
        check("i_val_held", bus.i_val, held_i);
        check("q_val_held", bus.q_val, held_q);
      end
    end
  end

  task automatic next_sample(output bit v, output int iv, output int qv);
    logic signed [15:0] r;
    if (fv.size() != 0) begin
      v  = (fv.pop_front() != 0);
      iv = fi.pop_front();
      qv = fq.pop_front();
    end else if (use_const) begin
      v  = 1'b1;
      iv = const_i;
      qv = const_q;
    end else begin
      v  = 1'b1;
      r  = 16'($urandom);
      iv = r;
      r  = 16'($urandom);
      qv = r;
    end
  endtask

  task automatic apply_stimulus(input int delay, input int len, input int pct,
                                input int mid_trig, input bit emit_trig);
    longint si = 0;
    longint sq = 0;
    int     cnt = 0;
    int     j = 0;
    bit     v;
    int     iv;
    int     qv;
    @(posedge clk100); #1;
    bus.trigger      = 1'b1;
    bus.win_delay    = 16'(delay);
    bus.win_len      = 16'(len);
    bus.sample_valid = 1'b1;
    bus.i_sample     = 16'sd1234;
    bus.q_sample     = -16'sd99;
    @(negedge clk100);
    check("overrun_on_start", bus.overrun, 0);
    while (cnt < delay + len) begin
      @(posedge clk100); #1;
      bus.trigger = (j == mid_trig);
      if (bus.trigger) begin
        bus.win_len   = 16'($urandom_range(0, 3));
        bus.win_delay = 16'($urandom_range(0, 3));
      end
      next_sample(v, iv, qv);
      if (v && pct < 100 && fv.size() == 0 && !use_const)
        v = ($urandom_range(99) < pct);
      bus.sample_valid = v;
      bus.i_sample     = 16'(iv);
      bus.q_sample     = 16'(qv);
      if (v) begin
        cnt++;
        if (cnt > delay) begin
          si += iv;
          sq += qv;
        end
        if (cnt == delay + len) exp_q.push_back('{si, sq, cyc + 1});
      end
      @(negedge clk100);
      check("busy_in_window", bus.busy, 1);
      check("overrun_in_window", bus.overrun, (j == mid_trig) ? 1 : 0);
      j++;
    end
    @(posedge clk100); #1;
    bus.sample_valid = 1'b0;
    bus.trigger      = emit_trig;
    bus.win_len      = 16'd5;
    @(negedge clk100);
    check("busy_in_emit", bus.busy, 1);
    check("overrun_in_emit", bus.overrun, emit_trig ? 1 : 0);
    @(posedge clk100); #1;
    bus.trigger = 1'b0;
    @(negedge clk100);
    check("busy_after_emit", bus.busy, 0);
    check("overrun_idle", bus.overrun, 0);
  endtask

  task automatic check_output_reset();
    check("rst_i_val", bus.i_val, 0);
    check("rst_q_val", bus.q_val, 0);
    check("rst_data_out", bus.data_out, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", bus.overrun, 0);
  endtask

  initial begin
    int waited;
    errors = 0;
    checks = 0;
    held_i = 0;
    held_q = 0;
    use_const = 1'b0;
    rst_n = 1'b0;
    bus.trigger = 1'b0;
    bus.win_delay = '0;
    bus.win_len = '0;
    bus.sample_valid = 1'b0;
    bus.i_sample = '0;
    bus.q_sample = '0;
    #1;
    check_output_reset();
    repeat (3) @(posedge clk100);
    #1 rst_n = 1'b1;

    fv = '{1, 1, 1, 1};
    fi = '{-3, -2, -1, 0};
    fq = '{-3, -2, -1, 0};
    apply_stimulus(0, 4, 100, -1, 1'b0);

    fv = '{1, 1, 1, 1, 1};
    fi = '{10, 20, 1, 2, 3};
    fq = '{-10, -20, -1, -2, -3};
    apply_stimulus(2, 3, 100, -1, 1'b0);

    fv = '{1, 0, 0, 1, 0, 1};
    fi = '{5, 5, 5, 5, 5, 5};
    fq = '{5, 5, 5, 5, 5, 5};
    apply_stimulus(0, 3, 100, -1, 1'b0);

    apply_stimulus(1, 5, 100, 3, 1'b1);

    // A zero-length trigger in IDLE is rejected and never starts a window.
    @(posedge clk100); #1;
    bus.trigger = 1'b1;
    bus.win_len = '0;
    bus.win_delay = 16'd3;
    @(negedge clk100);
    check("overrun_len0", bus.overrun, 1);
    check("busy_len0", bus.busy, 0);
    @(posedge clk100); #1;
    bus.trigger = 1'b0;
    @(negedge clk100);
    check("busy_after_len0", bus.busy, 0);

    for (int n = 0; n < 25; n++) begin
      apply_stimulus($urandom_range(0, 4), $urandom_range(1, 12), $urandom_range(30, 100),
                     ($urandom_range(3) == 0) ? int'($urandom_range(0, 8)) : -1,
                     1'($urandom_range(0, 1)));
    end

    use_const = 1'b1;
    const_i = -32768;
    const_q = 32767;
    apply_stimulus(0, 65535, 100, -1, 1'b0);
    use_const = 1'b0;

    // Reset in the middle of INTEGRATE abandons the window without a strobe.
    @(posedge clk100); #1;
    bus.trigger = 1'b1;
    bus.win_delay = '0;
    bus.win_len = 16'd10;
    bus.sample_valid = 1'b0;
    repeat (3) begin
      @(posedge clk100); #1;
      bus.trigger = 1'b0;
      bus.sample_valid = 1'b1;
      bus.i_sample = 16'sd7;
      bus.q_sample = -16'sd7;
    end
    #2 rst_n = 1'b0;
    #1;
    check_output_reset();
    held_i = 0;
    held_q = 0;
    @(posedge clk100); #1;
    bus.sample_valid = 1'b0;
    repeat (2) @(posedge clk100);
    #1 rst_n = 1'b1;
    apply_stimulus(1, 3, 100, -1, 1'b0);

    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(posedge clk100);
      waited++;
    end
    check("pending_strobes", exp_q.size(), 0);
    repeat (3) @(posedge clk100);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
